// File: rtl/hdr_mode_sequencer_if.sv
// Bus between the I3C engine side and the HDR mode sequencer.
// The master drives the command/handshake inputs and the slave (sequencer)
// drives the enables, special address, status pulses and statistics.
interface hdr_mode_sequencer_if #(
  parameter int NUM_ENG = 2,
  parameter int SEL_W   = 1,
  parameter int ADDR_W  = 8,
  parameter int TMO_W   = 16
);
  logic                i_en;
  logic [2:0]          i_mode;
  logic                i_cp;
  logic                i_toc;
  logic [SEL_W-1:0]    i_eng_sel;
  logic [TMO_W-1:0]    i_tmo_limit;
  logic                i_ccc_done;
  logic [NUM_ENG-1:0]  i_eng_done;
  logic                o_ccc_en;
  logic [NUM_ENG-1:0]  o_eng_en;
  logic [ADDR_W-1:0]   o_regf_addr_special;
  logic                o_done;
  logic                o_abort;
  logic                o_busy;
  logic [7:0]          o_cmd_cnt;

  modport master (
    output i_en, i_mode, i_cp, i_toc, i_eng_sel, i_tmo_limit, i_ccc_done, i_eng_done,
    input  o_ccc_en, o_eng_en, o_regf_addr_special, o_done, o_abort, o_busy, o_cmd_cnt
  );

  modport slave (
    input  i_en, i_mode, i_cp, i_toc, i_eng_sel, i_tmo_limit, i_ccc_done, i_eng_done,
    output o_ccc_en, o_eng_en, o_regf_addr_special, o_done, o_abort, o_busy, o_cmd_cnt
  );
endinterface

// File: rtl/hdr_mode_sequencer.sv
// HDR session sequencer: chains CCC and HDR transfer commands inside one
// HDR session using TOC/CP, inserts the dummy CCC fetch before a switch from
// CCC to a normal transfer, guards every command with a watchdog and keeps a
// saturating count of completed commands. All outputs are registered.
module hdr_mode_sequencer #(
  parameter int NUM_ENG    = 2,
  parameter int SEL_W      = 1,
  parameter int ADDR_W     = 8,
  parameter int CCC_ADDR   = 10,
  parameter int DUMMY_ADDR = 9,
  parameter int HDR_MODE   = 6,
  parameter int TMO_W      = 16
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst_n,
  hdr_mode_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CCC, S_DUMMY, S_ENG, S_HANDOFF, S_DONE, S_ABORT
  } state_e;

  state_e              state_q, state_d;
  state_e              nxt_q, nxt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [TMO_W-1:0]    wdog_q;
  logic                hit;
  logic                sel_ok;
  logic                tmo_hit;
  logic                hdr_on;

  logic                ccc_en_q, ccc_en_d;
  logic [NUM_ENG-1:0]  eng_en_q, eng_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                busy_q, busy_d;

  function automatic logic [NUM_ENG-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [NUM_ENG-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (s == SEL_W'(k)) oh[k] = 1'b1;
    end
    return oh;
  endfunction

  function automatic logic is_active(input state_e s);
    return (s == S_CCC) || (s == S_DUMMY) || (s == S_ENG);
  endfunction

  assign sel_ok  = (int'(bus.i_eng_sel) < NUM_ENG);
  assign hdr_on  = (bus.i_mode == 3'(HDR_MODE));
  assign tmo_hit = (bus.i_tmo_limit != '0) && (wdog_q == bus.i_tmo_limit);

  // State, pending post-handoff target, command count and output registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q  <= S_IDLE;
      nxt_q    <= S_IDLE;
      cnt_q    <= 8'd0;
      ccc_en_q <= 1'b0;
      eng_en_q <= '0;
      addr_q   <= ADDR_W'(CCC_ADDR);
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      ccc_en_q <= ccc_en_d;
      eng_en_q <= eng_en_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
    end
  end

  // Engine select and watchdog; both are (re)loaded before they are ever used.
  always_ff @(posedge i_sys_clk) begin
    sel_q <= sel_d;
    if (is_active(state_d) && (state_d != state_q)) begin
      wdog_q <= '0;
    end else if (is_active(state_q) && (wdog_q != '1)) begin
      wdog_q <= wdog_q + TMO_W'(1);
    end
  end

  // Next-state: dispatch, chaining on completion, mode loss and timeout.
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    case (state_q)
      S_CCC, S_DUMMY: hit = bus.i_ccc_done;
      S_ENG:          hit = |(bus.i_eng_done & sel_onehot(sel_q));
      default:        hit = 1'b0;
    endcase

    if (!bus.i_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hdr_on) begin
            state_d = S_DONE;
          end else begin
            cnt_d = 8'd0;
            if (bus.i_cp) begin
              state_d = S_CCC;
            end else if (!sel_ok) begin
              state_d = S_ABORT;
            end else begin
              sel_d   = bus.i_eng_sel;
              state_d = S_ENG;
            end
          end
        end
        S_CCC, S_DUMMY, S_ENG: begin
          if (hit) begin
            // The dummy fetch is bookkeeping only: not counted, never exits.
            if ((state_q != S_DUMMY) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
            if ((state_q != S_DUMMY) && bus.i_toc) begin
              state_d = S_DONE;
            end else if ((state_q == S_CCC) && !bus.i_cp) begin
              nxt_d   = S_DUMMY;
              state_d = S_HANDOFF;
            end else if ((state_q != S_DUMMY) && bus.i_cp) begin
              nxt_d   = S_CCC;
              state_d = S_HANDOFF;
            end else if (!sel_ok) begin
              state_d = S_ABORT;
            end else begin
              sel_d   = bus.i_eng_sel;
              nxt_d   = S_ENG;
              state_d = S_HANDOFF;
            end
          end else if (!hdr_on) begin
            state_d = S_DONE;
          end else if (tmo_hit) begin
            state_d = S_ABORT;
          end
        end
        S_HANDOFF: state_d = nxt_q;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    ccc_en_d = (state_d == S_CCC) || (state_d == S_DUMMY);
    eng_en_d = (state_d == S_ENG) ? sel_onehot(sel_d) : '0;
    addr_d   = (state_d == S_DUMMY) ? ADDR_W'(DUMMY_ADDR) : ADDR_W'(CCC_ADDR);
    done_d   = (state_d == S_DONE) || (state_d == S_ABORT);
    abort_d  = (state_d == S_ABORT);
    busy_d   = (state_d != S_IDLE);
  end

  assign bus.o_ccc_en            = ccc_en_q;
  assign bus.o_eng_en            = eng_en_q;
  assign bus.o_regf_addr_special = addr_q;
  assign bus.o_done              = done_q;
  assign bus.o_abort             = abort_q;
  assign bus.o_busy              = busy_q;
  assign bus.o_cmd_cnt           = cnt_q;

endmodule

// File: tb/tb_hdr_mode_sequencer.sv
// Directed bench for hdr_mode_sequencer: a session-level reference model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_hdr_mode_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  hdr_mode_sequencer_if #(.NUM_ENG(2), .SEL_W(1), .ADDR_W(8), .TMO_W(16)) bus ();

  hdr_mode_sequencer #(
    .NUM_ENG(2), .SEL_W(1), .ADDR_W(8), .CCC_ADDR(10), .DUMMY_ADDR(9),
    .HDR_MODE(6), .TMO_W(16)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Session-level reference: what is running now, what follows the gap.
  localparam int M_IDLE = 0, M_CCC = 1, M_DUMMY = 2, M_ENG = 3, M_GAP = 4, M_FIN = 5;
  int m_act = M_IDLE, m_after = M_IDLE, m_sel = 0, m_cnt = 0, m_age = 0;
  bit m_abort = 1'b0;
  bit m_fin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = M_IDLE; m_cnt = 0; m_abort = 1'b0;
    end else if (!bus.i_en) begin
      m_act = M_IDLE;
    end else begin
      case (m_act)
        M_IDLE: begin
          if (bus.i_mode != 3'd6) begin
            m_act = M_FIN; m_abort = 1'b0;
          end else begin
            m_cnt = 0; m_age = 0; m_sel = int'(bus.i_eng_sel);
            m_act = bus.i_cp ? M_CCC : M_ENG;
          end
        end
        M_CCC, M_DUMMY, M_ENG: begin
          m_fin = (m_act == M_ENG) ? bus.i_eng_done[m_sel] : bus.i_ccc_done;
          if (m_fin) begin
            if (m_act != M_DUMMY && m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_act != M_DUMMY && bus.i_toc) begin
              m_act = M_FIN; m_abort = 1'b0;
            end else begin
              if (m_act == M_DUMMY) m_after = M_ENG;
              else if (bus.i_cp) m_after = M_CCC;
              else m_after = (m_act == M_CCC) ? M_DUMMY : M_ENG;
              if (m_after == M_ENG) m_sel = int'(bus.i_eng_sel);
              m_act = M_GAP;
            end
          end else if (bus.i_mode != 3'd6) begin
            m_act = M_FIN; m_abort = 1'b0;
          end else if (bus.i_tmo_limit != 16'd0 && m_age == int'(bus.i_tmo_limit)) begin
            m_act = M_FIN; m_abort = 1'b1;
          end else begin
            m_age = m_age + 1;
          end
        end
        M_GAP: begin m_act = m_after; m_age = 0; end
        default: m_act = M_IDLE;
      endcase
    end
  end

  function automatic logic [31:0] model_vec();
    logic [1:0] e_eng;
    logic [7:0] e_addr;
    e_eng  = (m_act == M_ENG) ? ((m_sel == 0) ? 2'b01 : 2'b10) : 2'b00;
    e_addr = (m_act == M_DUMMY) ? 8'd9 : 8'd10;
    return {10'd0, (m_act == M_CCC || m_act == M_DUMMY), e_eng, e_addr,
            (m_act == M_FIN), (m_act == M_FIN && m_abort), (m_act != M_IDLE), 8'(m_cnt)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {10'd0, bus.o_ccc_en, bus.o_eng_en, bus.o_regf_addr_special,
            bus.o_done, bus.o_abort, bus.o_busy, bus.o_cmd_cnt};
  endfunction

  // Every cycle, away from the active edge.
  always @(negedge clk) chk("cycle_outputs", dut_vec(), model_vec());

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.i_en = 1'b0; bus.i_mode = 3'd6; bus.i_cp = 1'b0; bus.i_toc = 1'b0;
    bus.i_eng_sel = 1'b0; bus.i_tmo_limit = 16'd0; bus.i_ccc_done = 1'b0; bus.i_eng_done = 2'b00;
    tick(); tick();
    chk("reset_addr", 32'(bus.o_regf_addr_special), 32'd10);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // CCC with TOC=1
    bus.i_cp = 1'b1; bus.i_toc = 1'b1; bus.i_en = 1'b1;
    tick();
    chk("t1_ccc_en", 32'(bus.o_ccc_en), 32'd1);
    bus.i_ccc_done = 1'b1;
    tick();
    bus.i_ccc_done = 1'b0; bus.i_en = 1'b0;
    chk("t1_done", 32'(bus.o_done), 32'd1);
    chk("t1_cnt", 32'(bus.o_cmd_cnt), 32'd1);
    tick();
    chk("t1_done_low", 32'(bus.o_done), 32'd0);

    // CCC -> dummy -> engine 1
    bus.i_cp = 1'b1; bus.i_toc = 1'b0; bus.i_en = 1'b1;
    tick();
    bus.i_cp = 1'b0; bus.i_eng_sel = 1'b1; bus.i_ccc_done = 1'b1;
    tick();
    bus.i_ccc_done = 1'b0;
    chk("t2_gap1", 32'({bus.o_ccc_en, bus.o_eng_en}), 32'd0);
    tick();
    chk("t2_dummy_addr", 32'(bus.o_regf_addr_special), 32'd9);
    chk("t2_dummy_en", 32'(bus.o_ccc_en), 32'd1);
    bus.i_ccc_done = 1'b1;
    tick();
    bus.i_ccc_done = 1'b0;
    tick();
    chk("t2_eng_en", 32'(bus.o_eng_en), 32'b10);
    bus.i_toc = 1'b1; bus.i_eng_done = 2'b10;
    tick();
    bus.i_eng_done = 2'b00; bus.i_en = 1'b0;
    chk("t2_done", 32'(bus.o_done), 32'd1);
    chk("t2_cnt", 32'(bus.o_cmd_cnt), 32'd2);
    tick();

    // DDR chain of three with a stray done from engine 1
    bus.i_cp = 1'b0; bus.i_eng_sel = 1'b0; bus.i_toc = 1'b0; bus.i_en = 1'b1;
    tick();
    bus.i_eng_done = 2'b10;
    tick();
    chk("t3_stray_ignored", 32'(bus.o_eng_en), 32'b01);
    for (int i = 0; i < 2; i++) begin
      bus.i_eng_done = 2'b01;
      tick();
      bus.i_eng_done = 2'b00;
      chk("t3_gap", 32'(bus.o_eng_en), 32'd0);
      tick();
    end
    bus.i_toc = 1'b1; bus.i_eng_done = 2'b01;
    tick();
    bus.i_eng_done = 2'b00; bus.i_en = 1'b0;
    chk("t3_cnt", 32'(bus.o_cmd_cnt), 32'd3);
    tick();

    // Watchdog: limit 5, no done -> abort 6 cycles after enable rises
    bus.i_tmo_limit = 16'd5; bus.i_cp = 1'b1; bus.i_toc = 1'b1; bus.i_en = 1'b1;
    tick();
    repeat (5) tick();
    chk("t4_no_abort_yet", 32'(bus.o_abort), 32'd0);
    tick();
    chk("t4_abort", 32'({bus.o_abort, bus.o_done}), 32'b11);
    bus.i_en = 1'b0;
    tick();
    // Done at count 5 wins over the timeout
    bus.i_en = 1'b1;
    tick();
    repeat (5) tick();
    bus.i_ccc_done = 1'b1;
    tick();
    bus.i_ccc_done = 1'b0; bus.i_en = 1'b0;
    chk("t4_done_wins", 32'({bus.o_abort, bus.o_done}), 32'b01);
    bus.i_tmo_limit = 16'd0;
    tick();

    // Mode lost during ENG
    bus.i_cp = 1'b0; bus.i_toc = 1'b0; bus.i_en = 1'b1;
    tick(); tick();
    bus.i_mode = 3'd3;
    tick();
    chk("t5_mode_exit", 32'({bus.o_eng_en, bus.o_done, bus.o_abort}), 32'b0010);
    bus.i_mode = 3'd6; bus.i_en = 1'b0;
    tick();
    // Enable dropped mid-CCC
    bus.i_cp = 1'b1; bus.i_en = 1'b1;
    tick(); tick();
    bus.i_en = 1'b0;
    tick();
    chk("t5_en_drop", 32'({bus.o_ccc_en, bus.o_busy, bus.o_done}), 32'd0);
    tick();

    // Count saturation over a long CCC chain
    bus.i_cp = 1'b1; bus.i_toc = 1'b0; bus.i_en = 1'b1;
    tick();
    repeat (260) begin
      bus.i_ccc_done = 1'b1; tick();
      bus.i_ccc_done = 1'b0; tick();
    end
    chk("t6_cnt_sat", 32'(bus.o_cmd_cnt), 32'd255);
    bus.i_en = 1'b0;
    tick();

    // Async reset mid-DUMMY
    bus.i_cp = 1'b1; bus.i_en = 1'b1;
    tick();
    bus.i_cp = 1'b0; bus.i_ccc_done = 1'b1;
    tick();
    bus.i_ccc_done = 1'b0;
    tick();
    chk("t7_in_dummy", 32'(bus.o_regf_addr_special), 32'd9);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_addr", 32'(bus.o_regf_addr_special), 32'd10);
    chk("t7_rst_outs", 32'({bus.o_ccc_en, bus.o_eng_en, bus.o_done, bus.o_abort, bus.o_busy, bus.o_cmd_cnt}), 32'd0);
    bus.i_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
